// File: rtl/dpram_fifo_ctrl_if.sv
// Push/pop and RAM-port bundle for dpram_fifo_ctrl.
// The producer/consumer side is the master; the controller is the slave.
interface dpram_fifo_ctrl_if #(
  parameter int RAM_WIDTH = 8,
  parameter int ADDR_SZ   = 4
);
  logic                 push;
  logic [RAM_WIDTH-1:0] push_data;
  logic                 pop;
  logic [RAM_WIDTH-1:0] ram_data_in;
  logic [ADDR_SZ-1:0]   ram_wr_address;
  logic                 ram_write;
  logic [ADDR_SZ-1:0]   ram_rd_address;
  logic                 ram_read;
  logic                 rd_valid;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic [ADDR_SZ:0]     count;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output push, push_data, pop,
    input  ram_data_in, ram_wr_address, ram_write,
    input  ram_rd_address, ram_read, rd_valid,
    input  full, empty, almost_full, count,
    input  overflow, underflow
  );

  modport slave (
    input  push, push_data, pop,
    output ram_data_in, ram_wr_address, ram_write,
    output ram_rd_address, ram_read, rd_valid,
    output full, empty, almost_full, count,
    output overflow, underflow
  );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving both ports of a 16x8 dual-port RAM.
// Tracks occupancy, full/empty, sticky errors and read-data valid.
module dpram_fifo_ctrl #(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_DEPTH = 16,
  parameter int ADDR_SZ   = 4,
  parameter int AF_LEVEL  = 12
) (
  input  logic              clk,
  input  logic              reset,
  dpram_fifo_ctrl_if.slave  bus
);

  localparam logic [ADDR_SZ:0] C_DEPTH =
    (ADDR_SZ+1)'(RAM_DEPTH);
  localparam logic [ADDR_SZ:0] C_AF =
    (ADDR_SZ+1)'(AF_LEVEL);

  logic [ADDR_SZ-1:0]   r_wr_ptr;
  logic [ADDR_SZ-1:0]   r_rd_ptr;
  logic [ADDR_SZ:0]     r_count;
  logic                 r_rd_valid;
  logic                 r_overflow;
  logic                 r_underflow;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr;
  logic                 w_rd;
  logic [RAM_WIDTH-1:0] w_data;

  // Status decodes from the registered count; strobes gated by reset.
  always_comb begin
    w_full  = (r_count == C_DEPTH);
    w_empty = (r_count == '0);
    w_wr    = bus.push & ~w_full & ~reset;
    w_rd    = bus.pop & ~w_empty & ~reset;
    w_data  = bus.push_data;
  end

  assign bus.ram_data_in    = w_data;
  assign bus.ram_wr_address = r_wr_ptr;
  assign bus.ram_write      = w_wr;
  assign bus.ram_rd_address = r_rd_ptr;
  assign bus.ram_read       = w_rd;
  assign bus.rd_valid       = r_rd_valid;
  assign bus.full           = w_full;
  assign bus.empty          = w_empty;
  assign bus.almost_full    = (r_count >= C_AF);
  assign bus.count          = r_count;
  assign bus.overflow       = r_overflow;
  assign bus.underflow      = r_underflow;

  // Pointers, occupancy, read-valid and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_rd)
        r_count <= r_count + 1'b1;
      else if (w_rd && !w_wr)
        r_count <= r_count - 1'b1;
      if (bus.push && w_full)
        r_overflow <= 1'b1;
      if (bus.pop && w_empty)
        r_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl with a behavioural 16x8 RAM
// and a queue scoreboard of expected popped data.
module tb_dpram_fifo_ctrl;

  logic clk;
  logic reset;

  dpram_fifo_ctrl_if #(.RAM_WIDTH(8), .ADDR_SZ(4)) bus ();

  dpram_fifo_ctrl #(
    .RAM_WIDTH(8),
    .RAM_DEPTH(16),
    .ADDR_SZ(4),
    .AF_LEVEL(12)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [16];
  logic [7:0] dout;

  always @(posedge clk) begin
    if (bus.ram_write)
      mem[bus.ram_wr_address] <= bus.ram_data_in;
    if (bus.ram_read)
      dout <= mem[bus.ram_rd_address];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] sb_q [$];
  logic [3:0] m_wp = '0;
  logic [3:0] m_rp = '0;
  int         m_cnt = 0;
  logic       m_rdv = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  logic [7:0] m_dout = '0;

  task automatic step(input logic rst, input logic ps,
                      input logic [7:0] d, input logic pp);
    logic ew;
    logic er;
    @(negedge clk);
    reset = rst;
    bus.push = ps;
    bus.push_data = d;
    bus.pop = pp;
    #1;
    ew = ps && !rst && (m_cnt != 16);
    er = pp && !rst && (m_cnt != 0);
    chk("ram_write", 32'(bus.ram_write), 32'(ew));
    chk("ram_read", 32'(bus.ram_read), 32'(er));
    chk("ram_data_in", 32'(bus.ram_data_in), 32'(d));
    chk("wr_addr", 32'(bus.ram_wr_address), 32'(m_wp));
    chk("rd_addr", 32'(bus.ram_rd_address), 32'(m_rp));
    chk("count", 32'(bus.count), 32'(m_cnt));
    chk("full", 32'(bus.full), 32'(m_cnt == 16));
    chk("empty", 32'(bus.empty), 32'(m_cnt == 0));
    chk("almost_full", 32'(bus.almost_full),
        32'(m_cnt >= 12));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_udf));
    chk("rd_valid", 32'(bus.rd_valid), 32'(m_rdv));
    if (m_rdv)
      chk("data_out", 32'(dout), 32'(m_dout));
    if (rst) begin
      m_wp = '0;
      m_rp = '0;
      m_cnt = 0;
      m_rdv = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
      sb_q.delete();
    end else begin
      if (ps && m_cnt == 16) m_ovf = 1'b1;
      if (pp && m_cnt == 0) m_udf = 1'b1;
      m_rdv = er;
      if (er) begin
        if (sb_q.size() == 0) begin
          chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
          m_dout = sb_q.pop_front();
        end
        m_rp = m_rp + 4'd1;
      end
      if (ew) begin
        sb_q.push_back(d);
        m_wp = m_wp + 4'd1;
      end
      if (ew && !er) m_cnt++;
      if (er && !ew) m_cnt--;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.push = 1'b1;
    bus.pop = 1'b1;
    bus.push_data = 8'h00;
    @(posedge clk);
    step(1, 1, 8'h11, 1);
    step(1, 1, 8'h22, 1);
    // fill, then overflow
    for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 0);
    step(0, 1, 8'hAA, 0);
    step(0, 0, 8'h00, 0);
    // drain, then underflow
    for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    // wrap-around
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 8'(8'h30 + i), 0);
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 1);
    for (int i = 0; i < 10; i++) step(0, 1, 8'(8'h50 + i), 0);
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
    // simultaneous push/pop at 5, empty, full
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'hC0 + i), 0);
    step(0, 1, 8'hC5, 1);
    step(0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'hE0, 1);
    step(0, 0, 8'h00, 0);
    for (int i = 0; i < 15; i++) step(0, 1, 8'(8'hD0 + i), 0);
    step(0, 1, 8'hBB, 1);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
    // reset mid-stream
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 8'(8'h60 + i), 0);
    step(0, 0, 8'h00, 1);
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h77, 0);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
